// File: rtl/frame_gen_pkg.sv
// rtl/frame_gen_pkg.sv - shared types and widths for the frame timing generator
// Contents: raster state enum, test pattern enum, coordinate and frame counter widths.
package frame_gen_pkg;

    localparam int COORD_W = 12;
    localparam int FCNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VBLANK = 2'd1,
        LINE   = 2'd2,
        HBLANK = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PAT_RAMP    = 2'd0,
        PAT_CHECKER = 2'd1,
        PAT_SOLID   = 2'd2,
        PAT_VRAMP   = 2'd3
    } pattern_t;

endpackage

// File: rtl/frame_timing_gen_if.sv
// rtl/frame_timing_gen_if.sv - sensor-style video output bundle of the frame timing generator
// Signals: oFVAL frame valid, oLVAL line/pixel valid, oDATA pixel, oX/oY coordinates,
//          oSOF/oEOF frame boundary pulses, oFRAME_CNT completed-frame count.
// Modports: master drives the bundle (generator), slave observes it (capture side).
interface frame_timing_gen_if #(
    parameter int DATA_W = 12
);
    logic                               oFVAL;
    logic                               oLVAL;
    logic [DATA_W-1:0]                  oDATA;
    logic [frame_gen_pkg::COORD_W-1:0]  oX;
    logic [frame_gen_pkg::COORD_W-1:0]  oY;
    logic                               oSOF;
    logic                               oEOF;
    logic [frame_gen_pkg::FCNT_W-1:0]   oFRAME_CNT;

    modport master (
        output oFVAL, oLVAL, oDATA, oX, oY, oSOF, oEOF, oFRAME_CNT
    );

    modport slave (
        input oFVAL, oLVAL, oDATA, oX, oY, oSOF, oEOF, oFRAME_CNT
    );
endinterface

// File: rtl/frame_pattern_gen.sv
// rtl/frame_pattern_gen.sv - combinational test pattern map (pattern, x, y, frame) -> pixel
// Ports: pattern select, column x, line y, frame_cnt in; pixel (DATA_W, truncated) out.
module frame_pattern_gen
    import frame_gen_pkg::*;
#(
    parameter int DATA_W = 12
) (
    input  pattern_t             pattern,
    input  logic [COORD_W-1:0]   x,
    input  logic [COORD_W-1:0]   y,
    input  logic [FCNT_W-1:0]    frame_cnt,
    output logic [DATA_W-1:0]    pixel
);

    always_comb begin
        pixel = '0;
        case (pattern)
            PAT_RAMP:    pixel = DATA_W'(x) + DATA_W'(frame_cnt);
            // 8x8 checkerboard keyed on bit 3 of each coordinate
            PAT_CHECKER: pixel = (x[3] ^ y[3]) ? '1 : '0;
            PAT_SOLID:   pixel = DATA_W'(frame_cnt);
            PAT_VRAMP:   pixel = DATA_W'(y);
            default:     pixel = '0;
        endcase
    end

endmodule

// File: rtl/frame_timing_gen.sv
// rtl/frame_timing_gen.sv - programmable raster timing source with selectable test patterns
// Ports: iCLK clock, iRST async active-high reset, iEN run request (acted on at frame
//        boundaries), iPATTERN pattern select (latched at frame start), vid video bundle out.
module frame_timing_gen
    import frame_gen_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 16,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 64,
    parameter int DATA_W   = 12
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iEN,
    input  logic [1:0]          iPATTERN,
    frame_timing_gen_if.master  vid
);

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_ACTIVE - 1);

    // One shared blanking counter serves both VBLANK and HBLANK.
    localparam int BLK_MAX = (V_BLANK > H_BLANK) ? V_BLANK : H_BLANK;
    localparam int BLK_W   = (BLK_MAX > 1) ? $clog2(BLK_MAX) : 1;
    localparam logic [BLK_W-1:0] VB_LAST = BLK_W'(V_BLANK - 1);
    localparam logic [BLK_W-1:0] HB_LAST = BLK_W'(H_BLANK - 1);

    state_t               state,    nx_state;
    logic [COORD_W-1:0]   x_cnt,    nx_x;
    logic [COORD_W-1:0]   y_cnt,    nx_y;
    logic [BLK_W-1:0]     blk_cnt,  nx_blk;
    pattern_t             pat_q,    nx_pat;
    logic [FCNT_W-1:0]    frame_cnt, nx_fcnt;

    logic                 fval_d, lval_d, sof_d, eof_d;
    logic [COORD_W-1:0]   x_d, y_d;
    logic [DATA_W-1:0]    data_d;
    logic [DATA_W-1:0]    pixel;

    logic                 fval_q, lval_q, sof_q, eof_q;
    logic [COORD_W-1:0]   x_q, y_q;
    logic [DATA_W-1:0]    data_q;

    // The pixel is computed from the next-cycle coordinates so that it lands in the
    // output register on the same edge as oLVAL/oX/oY. The frame counter only moves
    // on the edge where oFVAL falls, so its current value is the one for this frame.
    frame_pattern_gen #(
        .DATA_W (DATA_W)
    ) u_pattern (
        .pattern   (nx_pat),
        .x         (nx_x),
        .y         (nx_y),
        .frame_cnt (frame_cnt),
        .pixel     (pixel)
    );

    always_comb begin
        nx_state = state;
        nx_x     = x_cnt;
        nx_y     = y_cnt;
        nx_blk   = blk_cnt;
        nx_pat   = pat_q;
        nx_fcnt  = frame_cnt;

        case (state)
            IDLE: begin
                if (iEN) begin
                    nx_state = VBLANK;
                    nx_blk   = '0;
                end
            end
            VBLANK: begin
                if (blk_cnt == VB_LAST) begin
                    nx_blk = '0;
                    if (iEN) begin
                        nx_state = LINE;
                        nx_pat   = pattern_t'(iPATTERN);
                        nx_x     = '0;
                        nx_y     = '0;
                    end else begin
                        nx_state = IDLE;
                    end
                end else begin
                    nx_blk = blk_cnt + 1'b1;
                end
            end
            LINE: begin
                if (x_cnt == H_LAST) begin
                    nx_x   = '0;
                    nx_blk = '0;
                    if (y_cnt == V_LAST) begin
                        nx_state = VBLANK;
                        nx_y     = '0;
                        nx_fcnt  = frame_cnt + 1'b1;
                    end else begin
                        nx_state = HBLANK;
                    end
                end else begin
                    nx_x = x_cnt + 1'b1;
                end
            end
            HBLANK: begin
                if (blk_cnt == HB_LAST) begin
                    nx_state = LINE;
                    nx_blk   = '0;
                    nx_y     = y_cnt + 1'b1;
                end else begin
                    nx_blk = blk_cnt + 1'b1;
                end
            end
            default: begin
                nx_state = IDLE;
                nx_x     = '0;
                nx_y     = '0;
                nx_blk   = '0;
            end
        endcase

        // Output values for the cycle after this edge, derived from the next state.
        fval_d = (nx_state == LINE) || (nx_state == HBLANK);
        lval_d = (nx_state == LINE);
        x_d    = lval_d ? nx_x : '0;
        y_d    = fval_d ? nx_y : '0;
        data_d = lval_d ? pixel : '0;
        sof_d  = lval_d && (nx_x == '0) && (nx_y == '0);
        eof_d  = lval_d && (nx_x == H_LAST) && (nx_y == V_LAST);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state     <= IDLE;
            x_cnt     <= '0;
            y_cnt     <= '0;
            blk_cnt   <= '0;
            pat_q     <= PAT_RAMP;
            frame_cnt <= '0;
            fval_q    <= 1'b0;
            lval_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            data_q    <= '0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
        end else begin
            state     <= nx_state;
            x_cnt     <= nx_x;
            y_cnt     <= nx_y;
            blk_cnt   <= nx_blk;
            pat_q     <= nx_pat;
            frame_cnt <= nx_fcnt;
            fval_q    <= fval_d;
            lval_q    <= lval_d;
            x_q       <= x_d;
            y_q       <= y_d;
            data_q    <= data_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
        end
    end

    assign vid.oFVAL      = fval_q;
    assign vid.oLVAL      = lval_q;
    assign vid.oDATA      = data_q;
    assign vid.oX         = x_q;
    assign vid.oY         = y_q;
    assign vid.oSOF       = sof_q;
    assign vid.oEOF       = eof_q;
    assign vid.oFRAME_CNT = frame_cnt;

endmodule

// File: tb/tb_frame_timing_gen.sv
// tb/tb_frame_timing_gen.sv - scoreboard bench for frame_timing_gen on a 4x3 raster
module tb_frame_timing_gen;

    localparam int HA = 4;
    localparam int HB = 2;
    localparam int VA = 3;
    localparam int VB = 5;
    localparam int DW = 12;

    typedef struct {
        int x;
        int y;
        int data;
        bit sof;
        bit eof;
        int fcnt;
        int gap;
        bit from_idle;
    } pix_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [1:0] pattern = 2'd0;

    int vectors = 0;
    int errors  = 0;
    int cyc = 0;
    int start_cyc = 0;
    pix_t q[$];

    frame_timing_gen_if #(.DATA_W(DW)) vid ();

    frame_timing_gen #(
        .H_ACTIVE (HA),
        .H_BLANK  (HB),
        .V_ACTIVE (VA),
        .V_BLANK  (VB),
        .DATA_W   (DW)
    ) dut (
        .iCLK     (clk),
        .iRST     (rst),
        .iEN      (en),
        .iPATTERN (pattern),
        .vid      (vid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int exp_data(input int pat, input int x, input int y, input int f);
        logic [11:0] xv;
        logic [11:0] yv;
        xv = 12'(x);
        yv = 12'(y);
        case (pat)
            0:       return (x + f) % 4096;
            1:       return (xv[3] ^ yv[3]) ? 4095 : 0;
            2:       return f;
            default: return y;
        endcase
    endfunction

    // Frame-to-frame gap is VBLANK+1 cycles, line-to-line HBLANK+1, in-line 1.
    // A frame leaving IDLE has its first pixel VBLANK+1 cycles after iEN is driven.
    task automatic push_frame(input int pat, input int f, input bit from_idle);
        pix_t e;
        for (int y = 0; y < VA; y++) begin
            for (int x = 0; x < HA; x++) begin
                e.x         = x;
                e.y         = y;
                e.fcnt      = f % 256;
                e.data      = exp_data(pat, x, y, f % 256);
                e.sof       = (x == 0) && (y == 0);
                e.eof       = (x == HA - 1) && (y == VA - 1);
                e.gap       = (x != 0) ? 1 : ((y != 0) ? HB + 1 : VB + 1);
                e.from_idle = from_idle && (x == 0) && (y == 0);
                q.push_back(e);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk_zero(input string name);
        vectors++;
        if (vid.oFVAL !== 1'b0 || vid.oLVAL !== 1'b0 || vid.oDATA !== '0 || vid.oX !== '0 ||
            vid.oY !== '0 || vid.oSOF !== 1'b0 || vid.oEOF !== 1'b0) begin
            errors++;
            $display("FAIL %s: fval=%b lval=%b data=%0d x=%0d y=%0d sof=%b eof=%b, required all 0",
                     name, vid.oFVAL, vid.oLVAL, vid.oDATA, vid.oX, vid.oY, vid.oSOF, vid.oEOF);
        end
    endtask

    task automatic chk_fcnt(input string name, input int want);
        vectors++;
        if (int'(vid.oFRAME_CNT) !== want) begin
            errors++;
            $display("FAIL %s: frame_cnt=%0d required %0d", name, vid.oFRAME_CNT, want);
        end
    endtask

    task automatic wait_sof(input int n);
        int seen = 0;
        int t = 0;
        while (seen < n && t < 100 * n) begin
            step(1);
            t++;
            if (vid.oSOF === 1'b1) seen++;
        end
        if (seen < n) begin
            vectors++;
            errors++;
            $display("FAIL wait_sof: saw %0d sof pulses, required %0d", seen, n);
        end
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while (q.size() > 0 && t < budget) begin
            step(1);
            t++;
        end
        vectors++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected pixels never appeared, required 0", q.size());
        end
    endtask

    // Monitor: pops one expected pixel per oLVAL cycle, checks blanking outputs otherwise,
    // and checks the oFVAL run length and frame counter at every oFVAL fall.
    int  last_pix = 0;
    int  last_fcnt = 0;
    int  run_len = 0;
    bit  prev_fval = 1'b0;

    always @(negedge clk) begin
        pix_t e;
        int   gap;
        if (rst) begin
            run_len   = 0;
            prev_fval = 1'b0;
        end else begin
            if (vid.oLVAL === 1'b1) begin
                vectors++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pixel: x=%0d y=%0d data=%0d, required no pixel",
                             vid.oX, vid.oY, vid.oDATA);
                end else begin
                    e = q.pop_front();
                    if (int'(vid.oX) !== e.x || int'(vid.oY) !== e.y || int'(vid.oDATA) !== e.data ||
                        vid.oSOF !== e.sof || vid.oEOF !== e.eof || vid.oFVAL !== 1'b1 ||
                        int'(vid.oFRAME_CNT) !== e.fcnt) begin
                        errors++;
                        $display("FAIL pixel: got x=%0d y=%0d data=%0d sof=%b eof=%b fval=%b f=%0d, required x=%0d y=%0d data=%0d sof=%b eof=%b fval=1 f=%0d",
                                 vid.oX, vid.oY, vid.oDATA, vid.oSOF, vid.oEOF, vid.oFVAL, vid.oFRAME_CNT,
                                 e.x, e.y, e.data, e.sof, e.eof, e.fcnt);
                    end
                    gap = e.from_idle ? (cyc - start_cyc) : (cyc - last_pix);
                    vectors++;
                    if (gap != e.gap) begin
                        errors++;
                        $display("FAIL pixel_gap: x=%0d y=%0d gap=%0d cycles, required %0d",
                                 e.x, e.y, gap, e.gap);
                    end
                    last_fcnt = e.fcnt;
                end
                last_pix = cyc;
            end else begin
                vectors++;
                if (vid.oDATA !== '0 || vid.oX !== '0 || vid.oSOF !== 1'b0 || vid.oEOF !== 1'b0 ||
                    (vid.oFVAL !== 1'b1 && vid.oY !== '0)) begin
                    errors++;
                    $display("FAIL blank_outputs: fval=%b data=%0d x=%0d y=%0d sof=%b eof=%b, required data/x/sof/eof 0 and y 0 outside frame",
                             vid.oFVAL, vid.oDATA, vid.oX, vid.oY, vid.oSOF, vid.oEOF);
                end
            end
            if (vid.oFVAL === 1'b1) begin
                run_len++;
            end else if (prev_fval) begin
                vectors += 2;
                if (run_len != VA * HA + (VA - 1) * HB) begin
                    errors++;
                    $display("FAIL fval_len: %0d cycles, required %0d", run_len, VA * HA + (VA - 1) * HB);
                end
                if (int'(vid.oFRAME_CNT) !== (last_fcnt + 1) % 256) begin
                    errors++;
                    $display("FAIL fcnt_at_fall: %0d, required %0d", vid.oFRAME_CNT, (last_fcnt + 1) % 256);
                end
                run_len = 0;
            end
            prev_fval = (vid.oFVAL === 1'b1);
        end
    end

    initial begin
        step(2);
        chk_zero("reset_outputs");
        chk_fcnt("reset_fcnt", 0);
        rst = 1'b0;
        step(3);
        chk_zero("idle_outputs");

        // Four ramp frames, then pattern changes issued mid-frame take effect next frame.
        push_frame(0, 0, 1'b1);
        push_frame(0, 1, 1'b0);
        push_frame(0, 2, 1'b0);
        push_frame(0, 3, 1'b0);
        en        = 1'b1;
        pattern   = 2'd0;
        start_cyc = cyc;
        wait_sof(4);
        pattern = 2'd1;
        push_frame(1, 4, 1'b0);
        wait_sof(1);
        pattern = 2'd2;
        push_frame(2, 5, 1'b0);
        wait_sof(1);
        pattern = 2'd3;
        push_frame(3, 6, 1'b0);
        wait_sof(1);

        // Drop iEN during line 1: frame 6 completes, one VBLANK, then IDLE.
        step(7);
        en      = 1'b0;
        pattern = 2'd0;
        wait_drain(100);
        step(15);
        chk_zero("idle_after_stop");
        chk_fcnt("fcnt_after_stop", 7);

        // Restart from IDLE: the frame counter continues.
        push_frame(0, 7, 1'b1);
        en        = 1'b1;
        start_cyc = cyc;
        wait_sof(1);
        step(2);

        // Asynchronous reset mid-line.
        rst = 1'b1;
        #1;
        chk_zero("async_reset");
        chk_fcnt("async_reset_fcnt", 0);
        q.delete();
        step(2);

        // 257 ramp frames from a cleared counter: the last one carries frame_cnt 0 again.
        for (int f = 0; f <= 256; f++) push_frame(0, f, f == 0);
        rst       = 1'b0;
        start_cyc = cyc;
        wait_drain(257 * 21 + 100);
        en = 1'b0;
        step(30);
        chk_zero("final_idle");
        chk_fcnt("final_fcnt_wrap", 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/frame_timing_gen.md
Name: frame_timing_gen

Overview:
Camera-side timing source for the capture path. Produces sensor-style frame-valid, line-valid and pixel data from a programmable raster with selectable test patterns. Drives the capture/decimation logic and downstream IPU stages in simulation and bring-up, without the physical sensor. Stands in for the sensor's FVAL/LVAL/DATA outputs.

Parameters:
H_ACTIVE, 640, active pixels per line (>=2, <=4095)
H_BLANK, 16, LVAL-low cycles between lines inside a frame (>=1)
V_ACTIVE, 480, active lines per frame (>=1, <=4095)
V_BLANK, 64, FVAL-low cycles between frames (>=1)
DATA_W, 12, pixel width (>=8)

Ports:
iCLK  in  1  clock
iRST  in  1  reset; asynchronous, active-high
iEN  in  1  run request; start and stop take effect only at frame boundaries
iPATTERN  in  2  pattern select; latched at frame start
oFVAL  out  1  frame valid
oLVAL  out  1  line valid (pixel valid)
oDATA  out  DATA_W  pixel value; 0 when oLVAL=0
oX  out  12  pixel column; 0 when oLVAL=0
oY  out  12  line index; held during HBLANK, 0 in VBLANK/IDLE
oSOF  out  1  1-cycle pulse with first pixel of frame
oEOF  out  1  1-cycle pulse with last pixel of frame
oFRAME_CNT  out  8  completed-frame counter

Behaviour:
- All outputs registered; all change on the same iCLK edge. Reset (async, iRST=1) forces state IDLE, every output 0, internal counters 0, latched pattern 0.
- States: IDLE, VBLANK, LINE, HBLANK.
- IDLE: outputs 0. The edge that samples iEN=1 enters VBLANK.
- VBLANK: oFVAL=0 for exactly V_BLANK cycles. At the last cycle, sample iEN. If 0, go to IDLE. If 1, latch iPATTERN and enter LINE with oY=0, oX=0. oFVAL rises on the same edge as the first oLVAL.
- LINE: oFVAL=1, oLVAL=1 for H_ACTIVE cycles; oX counts 0..H_ACTIVE-1. After the last pixel:
  - if oY<V_ACTIVE-1, go to HBLANK;
  - otherwise go to VBLANK. oFVAL and oLVAL both fall the cycle after the last pixel.
- HBLANK: oFVAL=1, oLVAL=0 for H_BLANK cycles. Then LINE with oY+1.
- Frame period = V_BLANK + V_ACTIVE*H_ACTIVE + (V_ACTIVE-1)*H_BLANK cycles.
- iEN low mid-frame: the frame completes unchanged. IDLE is entered at the end of the following VBLANK; FVAL is never truncated.
- iPATTERN changes mid-frame are ignored until the next frame start.
- oSOF is high with (oX=0, oY=0). oEOF is high with (oX=H_ACTIVE-1, oY=V_ACTIVE-1). Both are high in the same cycle only if H_ACTIVE=1, which is disallowed.
- oFRAME_CNT increments by 1 on the edge where oFVAL falls; it wraps 255->0. Patterns use the value current during the frame, so the first frame uses 0.
- Patterns (f = oFRAME_CNT), computed in DATA_W bits with truncation:
  - 0 ramp: x + f
  - 1 checker: all-ones if x[3]^y[3], else 0
  - 2 solid: f zero-extended
  - 3 vertical ramp: y
- Async reset mid-frame: outputs drop to 0 immediately (oFVAL may fall mid-line). After release, the block restarts from IDLE.

Decomposition:
- Shared package frame_gen_pkg:
  - state enum (IDLE/VBLANK/LINE/HBLANK)
  - pattern enum (PAT_RAMP/PAT_CHECKER/PAT_SOLID/PAT_VRAMP)
  - coordinate width constant (12) and frame counter width (8)
- One sub-module, frame_pattern_gen: combinational map from (pattern, x, y, f) to DATA_W pixel, registered in the parent.
- Raster FSM and counters stay in frame_timing_gen.

Test Plan (H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_BLANK=5, DATA_W=12):
- Reset then iEN=1, iPATTERN=0 -> oFVAL rises 5 cycles after IDLE exit. oLVAL shows 3 runs of 4, separated by 2-cycle gaps. oFVAL is high 16 cycles, period 21. oDATA per line = 0,1,2,3. oSOF/oEOF are single pulses at the correct pixels.
- Run 3 frames with pattern 0 -> oFRAME_CNT steps 0,1,2,3 at each oFVAL fall. Frame 2 line data = 2,3,4,5.
- iPATTERN 0->1 mid-frame -> current frame stays ramp. Next frame is checker (all 0 for x,y<8). Pattern 2 in frame with f=5 -> every pixel 5.
- iEN dropped during line 1 -> that frame completes fully. One VBLANK of 5 cycles follows, then IDLE with all outputs 0. iEN re-asserted -> fresh frame, oFRAME_CNT continues (not reset).
- iRST pulsed mid-line -> all outputs 0 asynchronously. After release with iEN=1, a full VBLANK precedes the next oFVAL. oFRAME_CNT=0.
- Run 256 frames -> oFRAME_CNT wraps 255->0. Ramp data wraps modulo 4096 with no X.
